// File: rtl/timer_array_pkg.sv
// Shared definitions for the multi-channel timer: CONFIG/STATUS bit positions,
// per-channel word offsets and the packed CONFIG layout.
package timer_array_pkg;

  localparam int CFG_EN       = 0;
  localparam int CFG_ONESHOT  = 1;
  localparam int CFG_EXT      = 2;
  localparam int CFG_OVIE     = 3;
  localparam int CFG_CMPIE    = 4;
  localparam int CFG_PSEL_LSB = 5;

  localparam int STAT_OVF  = 0;
  localparam int STAT_CMPF = 1;

  localparam logic [1:0] CFG_STAT = 2'd0;
  localparam logic [1:0] CNT      = 2'd1;
  localparam logic [1:0] RLD      = 2'd2;
  localparam logic [1:0] CMP      = 2'd3;

  typedef struct packed {
    logic [2:0] psel;
    logic       cmpie;
    logic       ovie;
    logic       ext;
    logic       oneshot;
    logic       en;
  } timer_cfg_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: registers, external-event synchroniser, count/flag logic
// and per-lane combinational read data.
module timer_channel
  import timer_array_pkg::*;
#(
  parameter int PRESCALE_BITS = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PRESCALE_BITS-1:0] prescale,
  input  logic                     ext_in,
  input  logic                     wr_en_even,
  input  logic [1:0]               wr_off_even,
  input  logic [7:0]               wr_data_even,
  input  logic                     wr_en_odd,
  input  logic [1:0]               wr_off_odd,
  input  logic [7:0]               wr_data_odd,
  input  logic [1:0]               rd_off_even,
  input  logic [1:0]               rd_off_odd,
  output logic [7:0]               rd_data_even,
  output logic [7:0]               rd_data_odd,
  output logic [1:0]               irq
);

  timer_cfg_t cfg_q, cfg_d;
  logic [15:0] cnt_q, cnt_d, rld_q, rld_d, cmp_q, cmp_d;
  logic ovf_q, ovf_d, cmpf_q, cmpf_d;
  logic sync1, sync2, in_dly, rise;
  logic [2:0] psel_eff;
  logic [PRESCALE_BITS-1:0] ps_mask;
  logic tick, cnt_wr, count_ev;
  logic [7:0] stat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      in_dly <= 1'b0;
    end else begin
      sync1  <= ext_in;
      sync2  <= sync1;
      in_dly <= sync2;
    end
  end

  assign rise = sync2 & ~in_dly;

  // A tick fires when the low PSEL prescaler bits are all ones (always for PSEL 0).
  always_comb begin
    psel_eff = (32'(cfg_q.psel) > PRESCALE_BITS) ? 3'(PRESCALE_BITS) : cfg_q.psel;
    ps_mask  = '0;
    for (int i = 0; i < PRESCALE_BITS; i++) ps_mask[i] = (i < int'(psel_eff));
    tick = &(prescale | ~ps_mask);
  end

  always_comb begin
    cfg_d  = cfg_q;
    cnt_d  = cnt_q;
    rld_d  = rld_q;
    cmp_d  = cmp_q;
    ovf_d  = ovf_q;
    cmpf_d = cmpf_q;
    cnt_wr   = (wr_en_even && wr_off_even == CNT) || (wr_en_odd && wr_off_odd == CNT);
    count_ev = cfg_q.en && (cfg_q.ext ? rise : tick) && !cnt_wr;

    // Clears are applied first so that a same-cycle flag set overrides them.
    if (wr_en_odd && wr_off_odd == CFG_STAT) begin
      if (wr_data_odd[STAT_OVF])  ovf_d  = 1'b0;
      if (wr_data_odd[STAT_CMPF]) cmpf_d = 1'b0;
    end

    if (count_ev) begin
      if (cnt_q == 16'hFFFF) begin
        cnt_d = rld_q;
        ovf_d = 1'b1;
        if (cfg_q.oneshot) cfg_d.en = 1'b0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      if (cnt_d == cmp_q) cmpf_d = 1'b1;
    end

    if (wr_en_even) begin
      case (wr_off_even)
        CFG_STAT: cfg_d = timer_cfg_t'(wr_data_even);
        CNT:      cnt_d[7:0] = wr_data_even;
        RLD:      rld_d[7:0] = wr_data_even;
        CMP:      cmp_d[7:0] = wr_data_even;
      endcase
    end
    if (wr_en_odd) begin
      case (wr_off_odd)
        CNT:     cnt_d[15:8] = wr_data_odd;
        RLD:     rld_d[15:8] = wr_data_odd;
        CMP:     cmp_d[15:8] = wr_data_odd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q  <= '0;
      cnt_q  <= '0;
      rld_q  <= '0;
      cmp_q  <= 16'hFFFF;
      ovf_q  <= 1'b0;
      cmpf_q <= 1'b0;
      irq    <= '0;
    end else begin
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      rld_q  <= rld_d;
      cmp_q  <= cmp_d;
      ovf_q  <= ovf_d;
      cmpf_q <= cmpf_d;
      irq    <= {cmpf_q & cfg_q.cmpie, ovf_q & cfg_q.ovie};
    end
  end

  always_comb begin
    stat            = '0;
    stat[STAT_OVF]  = ovf_q;
    stat[STAT_CMPF] = cmpf_q;
    rd_data_even    = '0;
    rd_data_odd     = '0;
    case (rd_off_even)
      CFG_STAT: rd_data_even = cfg_q;
      CNT:      rd_data_even = cnt_q[7:0];
      RLD:      rd_data_even = rld_q[7:0];
      CMP:      rd_data_even = cmp_q[7:0];
    endcase
    case (rd_off_odd)
      CFG_STAT: rd_data_odd = stat;
      CNT:      rd_data_odd = cnt_q[15:8];
      RLD:      rd_data_odd = rld_q[15:8];
      CMP:      rd_data_odd = cmp_q[15:8];
    endcase
  end

endmodule

// File: rtl/timer_array.sv
// Multi-channel 16-bit timer on the even/odd byte-lane register buses:
// shared prescaler, address decode, registered read mux and hit flags.
module timer_array
  import timer_array_pkg::*;
#(
  parameter int          NUM_CH        = 4,
  parameter logic [15:0] ADDRBASE      = 16'h0040,
  parameter int          PRESCALE_BITS = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [14:0]           read_addr_even,
  output logic [7:0]            read_data_even,
  output logic                  read_hit_even,
  input  logic [14:0]           write_addr_even,
  input  logic [7:0]            write_data_even,
  input  logic                  write_en_even,
  input  logic [14:0]           read_addr_odd,
  output logic [7:0]            read_data_odd,
  output logic                  read_hit_odd,
  input  logic [14:0]           write_addr_odd,
  input  logic [7:0]            write_data_odd,
  input  logic                  write_en_odd,
  input  logic [NUM_CH-1:0]     in,
  output logic [2*NUM_CH-1:0]   irq
);

  localparam logic [14:0] BASE_W = ADDRBASE[15:1];
  localparam logic [14:0] SPAN   = 15'(4 * NUM_CH);

  typedef struct packed {
    logic       hit;
    logic [2:0] ch;
    logic [1:0] off;
  } dec_t;

  function automatic dec_t decode(input logic [14:0] a);
    logic [14:0] rel;
    dec_t d;
    rel   = a - BASE_W;
    d.hit = (a >= BASE_W) && (rel < SPAN);
    d.ch  = rel[4:2];
    d.off = rel[1:0];
    return d;
  endfunction

  dec_t rd_e, rd_o, wr_e, wr_o;
  logic [PRESCALE_BITS-1:0] prescale;
  logic [7:0] ch_rd_even [NUM_CH];
  logic [7:0] ch_rd_odd  [NUM_CH];
  logic [7:0] rd_mux_even, rd_mux_odd;

  always_comb begin
    rd_e = decode(read_addr_even);
    rd_o = decode(read_addr_odd);
    wr_e = decode(write_addr_even);
    wr_o = decode(write_addr_odd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prescale <= '0;
    else       prescale <= prescale + 1'b1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    timer_channel #(.PRESCALE_BITS(PRESCALE_BITS)) u_ch (
      .clk          (clk),
      .reset        (reset),
      .prescale     (prescale),
      .ext_in       (in[c]),
      .wr_en_even   (write_en_even && wr_e.hit && wr_e.ch == 3'(c)),
      .wr_off_even  (wr_e.off),
      .wr_data_even (write_data_even),
      .wr_en_odd    (write_en_odd && wr_o.hit && wr_o.ch == 3'(c)),
      .wr_off_odd   (wr_o.off),
      .wr_data_odd  (write_data_odd),
      .rd_off_even  (rd_e.off),
      .rd_off_odd   (rd_o.off),
      .rd_data_even (ch_rd_even[c]),
      .rd_data_odd  (ch_rd_odd[c]),
      .irq          (irq[2*c +: 2])
    );
  end

  always_comb begin
    rd_mux_even = '0;
    rd_mux_odd  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_e.ch == 3'(c)) rd_mux_even = ch_rd_even[c];
      if (rd_o.ch == 3'(c)) rd_mux_odd  = ch_rd_odd[c];
    end
  end

  // A write to the address being read in the same cycle is forwarded to the reader.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_hit_even  <= 1'b0;
      read_hit_odd   <= 1'b0;
      read_data_even <= '0;
      read_data_odd  <= '0;
    end else begin
      read_hit_even <= rd_e.hit;
      read_hit_odd  <= rd_o.hit;
      if (!rd_e.hit)
        read_data_even <= '0;
      else if (write_en_even && write_addr_even == read_addr_even)
        read_data_even <= write_data_even;
      else
        read_data_even <= rd_mux_even;
      if (!rd_o.hit)
        read_data_odd <= '0;
      else if (write_en_odd && write_addr_odd == read_addr_odd)
        read_data_odd <= write_data_odd;
      else
        read_data_odd <= rd_mux_odd;
    end
  end

endmodule

// File: tb/tb_timer_array.sv
// Directed self-checking bench for timer_array with eight channels at the
// default base address (channel c words start at 15'h20 + 4c).
module tb_timer_array;

  localparam int NUM_CH = 8;

  logic                clk;
  logic                reset;
  logic [14:0]         read_addr_even, read_addr_odd;
  logic [7:0]          read_data_even, read_data_odd;
  logic                read_hit_even, read_hit_odd;
  logic [14:0]         write_addr_even, write_addr_odd;
  logic [7:0]          write_data_even, write_data_odd;
  logic                write_en_even, write_en_odd;
  logic [NUM_CH-1:0]   ext_in;
  logic [2*NUM_CH-1:0] irq;

  int checks = 0;
  int errors = 0;

  timer_array #(.NUM_CH(NUM_CH), .ADDRBASE(16'h0040), .PRESCALE_BITS(7)) dut (
    .clk             (clk),
    .reset           (reset),
    .read_addr_even  (read_addr_even),
    .read_data_even  (read_data_even),
    .read_hit_even   (read_hit_even),
    .write_addr_even (write_addr_even),
    .write_data_even (write_data_even),
    .write_en_even   (write_en_even),
    .read_addr_odd   (read_addr_odd),
    .read_data_odd   (read_data_odd),
    .read_hit_odd    (read_hit_odd),
    .write_addr_odd  (write_addr_odd),
    .write_data_odd  (write_data_odd),
    .write_en_odd    (write_en_odd),
    .in              (ext_in),
    .irq             (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL timeout observed no summary expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_rd(input logic [14:0] a);
    read_addr_even = a;
    read_addr_odd  = a;
    step();
  endtask

  task automatic apply_stimulus_wr16(input logic [14:0] a, input logic [15:0] d);
    write_addr_even = a;
    write_addr_odd  = a;
    write_data_even = d[7:0];
    write_data_odd  = d[15:8];
    write_en_even   = 1'b1;
    write_en_odd    = 1'b1;
    step();
    write_en_even   = 1'b0;
    write_en_odd    = 1'b0;
  endtask

  task automatic apply_stimulus_wr_even(input logic [14:0] a, input logic [7:0] d);
    write_addr_even = a;
    write_data_even = d;
    write_en_even   = 1'b1;
    step();
    write_en_even   = 1'b0;
  endtask

  task automatic apply_stimulus_wr_odd(input logic [14:0] a, input logic [7:0] d);
    write_addr_odd = a;
    write_data_odd = d;
    write_en_odd   = 1'b1;
    step();
    write_en_odd   = 1'b0;
  endtask

  function automatic logic [15:0] word();
    return {read_data_odd, read_data_even};
  endfunction

  function automatic logic [15:0] hits();
    return {14'h0, read_hit_odd, read_hit_even};
  endfunction

  initial begin
    logic [15:0] prev;
    int last;

    reset = 1'b1;
    read_addr_even = '0;  read_addr_odd = '0;
    write_addr_even = '0; write_addr_odd = '0;
    write_data_even = '0; write_data_odd = '0;
    write_en_even = 1'b0; write_en_odd = 1'b0;
    ext_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_irq", irq, 16'h0000);
    check_output("rst_hit_in_reset", hits(), 16'h0000);
    reset = 1'b0;

    // Reset values of every register in every channel
    for (int c = 0; c < NUM_CH; c++) begin
      for (int w = 0; w < 4; w++) begin
        apply_stimulus_rd(15'(32 + 4 * c + w));
        check_output($sformatf("rst_hit_ch%0d_w%0d", c, w), hits(), 16'h0003);
        check_output($sformatf("rst_val_ch%0d_w%0d", c, w), word(),
                     (w == 3) ? 16'hFFFF : 16'h0000);
      end
    end
    check_output("rst_irq_after", irq, 16'h0000);

    apply_stimulus_rd(15'h1F);
    check_output("unmapped_lo_hit", hits(), 16'h0000);
    check_output("unmapped_lo_data", word(), 16'h0000);
    apply_stimulus_rd(15'h40);
    check_output("unmapped_hi_hit", hits(), 16'h0000);
    check_output("unmapped_hi_data", word(), 16'h0000);

    // Channel 0: overflow with reload, interrupt, write-1-clear
    apply_stimulus_wr16(15'h22, 16'hFFF0);
    apply_stimulus_wr16(15'h21, 16'hFFFE);
    apply_stimulus_wr_even(15'h20, 8'h09);
    read_addr_even = 15'h21;
    read_addr_odd  = 15'h21;
    step();
    check_output("ch0_cnt_fffe", word(), 16'hFFFE);
    step();
    check_output("ch0_cnt_ffff", word(), 16'hFFFF);
    check_output("ch0_irq_before", {15'h0, irq[0]}, 16'h0000);
    step();
    check_output("ch0_cnt_reload", word(), 16'hFFF0);
    check_output("ch0_irq_ovf", {15'h0, irq[0]}, 16'h0001);
    apply_stimulus_rd(15'h20);
    check_output("ch0_cfg", {8'h00, read_data_even}, 16'h0009);
    check_output("ch0_stat_set", {8'h00, read_data_odd}, 16'h0003);
    apply_stimulus_wr_odd(15'h20, 8'h01);
    apply_stimulus_rd(15'h20);
    check_output("ch0_stat_clr", {8'h00, read_data_odd}, 16'h0002);
    check_output("ch0_irq_clr", {15'h0, irq[0]}, 16'h0000);
    apply_stimulus_wr_even(15'h20, 8'h00);

    // Channel 1: divide by 8, compare interrupt, one-shot
    apply_stimulus_wr16(15'h27, 16'h0005);
    apply_stimulus_wr_even(15'h24, 8'h73);
    read_addr_even = 15'h25;
    read_addr_odd  = 15'h25;
    prev = 16'h0000;
    last = -1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (word() !== prev) begin
        check_output("ch1_step", word(), prev + 16'd1);
        if (last >= 0) check_output("ch1_gap", 16'(i - last), 16'd8);
        prev = word();
        last = i;
        if (prev == 16'd5) break;
      end
    end
    check_output("ch1_reach5", prev, 16'h0005);
    check_output("ch1_irq_cmp", {15'h0, irq[3]}, 16'h0001);
    check_output("ch1_irq_ovf_masked", {15'h0, irq[2]}, 16'h0000);
    apply_stimulus_rd(15'h24);
    check_output("ch1_cfg_running", {8'h00, read_data_even}, 16'h0073);
    check_output("ch1_stat_cmpf", {8'h00, read_data_odd}, 16'h0002);
    apply_stimulus_wr16(15'h25, 16'hFFFE);
    repeat (24) step();
    apply_stimulus_rd(15'h24);
    check_output("ch1_cfg_oneshot", {8'h00, read_data_even}, 16'h0072);
    check_output("ch1_stat_ovf", {8'h00, read_data_odd}, 16'h0003);
    repeat (16) step();
    apply_stimulus_rd(15'h25);
    check_output("ch1_stopped", word(), 16'h0000);

    // Channel 2: external events, increment two edges after sampling
    apply_stimulus_wr_even(15'h28, 8'h05);
    read_addr_even = 15'h29;
    read_addr_odd  = 15'h29;
    for (int p = 0; p < 4; p++) begin
      ext_in[2] = 1'b1;
      step();
      step();
      step();
      check_output($sformatf("ch2_pre_%0d", p), word(), 16'(p));
      ext_in[2] = 1'b0;
      step();
      check_output($sformatf("ch2_post_%0d", p), word(), 16'(p + 1));
      step();
      step();
    end
    apply_stimulus_rd(15'h29);
    check_output("ch2_final", word(), 16'h0004);

    // Counter write collides with a count event
    apply_stimulus_wr_even(15'h20, 8'h01);
    apply_stimulus_wr16(15'h21, 16'h1234);
    read_addr_even = 15'h21;
    read_addr_odd  = 15'h21;
    apply_stimulus_wr_even(15'h20, 8'h00);
    check_output("col_cnt_write", word(), 16'h1234);

    // Overflow set collides with write-1-clear of OVF
    apply_stimulus_wr16(15'h21, 16'hFFFF);
    apply_stimulus_wr_even(15'h20, 8'h01);
    apply_stimulus_wr16(15'h20, 16'h0100);
    apply_stimulus_rd(15'h20);
    check_output("col_ovf_set_wins", {8'h00, read_data_odd}, 16'h0003);
    check_output("col_cfg_off", {8'h00, read_data_even}, 16'h0000);
    apply_stimulus_rd(15'h21);
    check_output("col_cnt_reload", word(), 16'hFFF0);

    // Same-cycle read and write of channel 3 RELOAD lo
    read_addr_even  = 15'h2E;
    read_addr_odd   = 15'h7FFF;
    write_addr_even = 15'h2E;
    write_data_even = 8'hA5;
    write_en_even   = 1'b1;
    step();
    write_en_even   = 1'b0;
    check_output("bypass_data", {8'h00, read_data_even}, 16'h00A5);
    check_output("bypass_hits", hits(), 16'h0001);
    check_output("bypass_odd_data", {8'h00, read_data_odd}, 16'h0000);
    apply_stimulus_rd(15'h2E);
    check_output("reload_stored", word(), 16'h00A5);

    // Reset while channels 4..7 are running with interrupts raised
    apply_stimulus_wr16(15'h31, 16'hFFFE);
    apply_stimulus_wr_even(15'h30, 8'h19);
    apply_stimulus_wr_even(15'h34, 8'h19);
    apply_stimulus_wr_even(15'h38, 8'h19);
    apply_stimulus_wr_even(15'h3C, 8'h19);
    apply_stimulus_rd(15'h30);
    check_output("pre_rst_irq_ch4", {14'h0, irq[9:8]}, 16'h0003);
    check_output("pre_rst_hit", hits(), 16'h0003);
    #2;
    reset = 1'b1;
    #1;
    check_output("mid_rst_irq", irq, 16'h0000);
    check_output("mid_rst_hit", hits(), 16'h0000);
    check_output("mid_rst_data", word(), 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply_stimulus_rd(15'h31);
    check_output("post_rst_cnt", word(), 16'h0000);
    apply_stimulus_rd(15'h30);
    check_output("post_rst_cfg_stat", word(), 16'h0000);
    apply_stimulus_rd(15'h3F);
    check_output("post_rst_cmp", word(), 16'hFFFF);
    check_output("post_rst_irq", irq, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
